// File: rtl/smc_pkg.sv
// Shared types and widths for the SMC frame loader.
// Imported by the loader and by the testbed around the SMC core.
package smc_pkg;

    localparam int N_MOS   = 6;
    localparam int PARAM_W = 3;
    localparam int MODE_W  = 2;
    localparam int OUT_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EVAL = 2'd2,
        OUT  = 2'd3
    } smc_ld_state_t;

endpackage

// File: rtl/smc_frame_loader.sv
// Serial-to-parallel frame loader in front of the combinational SMC core.
// Holds the parameter bus stable, samples the core, strobes one result.
module smc_frame_loader
    import smc_pkg::*;
#(
    parameter int EVAL_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [PARAM_W-1:0] in_w,
    input  logic [PARAM_W-1:0] in_vgs,
    input  logic [PARAM_W-1:0] in_vds,
    input  logic [MODE_W-1:0]  in_mode,
    output logic [PARAM_W-1:0] W_0,
    output logic [PARAM_W-1:0] W_1,
    output logic [PARAM_W-1:0] W_2,
    output logic [PARAM_W-1:0] W_3,
    output logic [PARAM_W-1:0] W_4,
    output logic [PARAM_W-1:0] W_5,
    output logic [PARAM_W-1:0] V_GS_0,
    output logic [PARAM_W-1:0] V_GS_1,
    output logic [PARAM_W-1:0] V_GS_2,
    output logic [PARAM_W-1:0] V_GS_3,
    output logic [PARAM_W-1:0] V_GS_4,
    output logic [PARAM_W-1:0] V_GS_5,
    output logic [PARAM_W-1:0] V_DS_0,
    output logic [PARAM_W-1:0] V_DS_1,
    output logic [PARAM_W-1:0] V_DS_2,
    output logic [PARAM_W-1:0] V_DS_3,
    output logic [PARAM_W-1:0] V_DS_4,
    output logic [PARAM_W-1:0] V_DS_5,
    output logic [MODE_W-1:0]  mode,
    input  logic [OUT_W-1:0]   smc_out_n,
    output logic               out_valid,
    output logic [OUT_W-1:0]   out_n,
    output logic               busy
);

    localparam logic [2:0] LAST_SLOT = 3'(N_MOS - 1);
    localparam logic [1:0] ECNT_LAST = 2'(EVAL_CYCLES - 1);

    smc_ld_state_t state;
    logic [2:0]    cnt;
    logic [1:0]    ecnt;
    logic          settled;

    logic [PARAM_W-1:0] w_q   [N_MOS];
    logic [PARAM_W-1:0] vgs_q [N_MOS];
    logic [PARAM_W-1:0] vds_q [N_MOS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ecnt      <= '0;
            settled   <= 1'b0;
            mode      <= '0;
            out_valid <= 1'b0;
            out_n     <= '0;
            for (int k = 0; k < N_MOS; k++) begin
                w_q[k]   <= '0;
                vgs_q[k] <= '0;
                vds_q[k] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        w_q[0]   <= in_w;
                        vgs_q[0] <= in_vgs;
                        vds_q[0] <= in_vds;
                        mode     <= in_mode;
                        cnt      <= 3'd1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        w_q[cnt]   <= in_w;
                        vgs_q[cnt] <= in_vgs;
                        vds_q[cnt] <= in_vds;
                        if (cnt == LAST_SLOT) begin
                            cnt     <= '0;
                            ecnt    <= '0;
                            settled <= 1'b0;
                            state   <= EVAL;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end else begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                EVAL: begin
                    // First EVAL cycle lets the last slot ripple through the core.
                    if (!settled) begin
                        settled <= 1'b1;
                    end else begin
                        ecnt <= ecnt + 2'd1;
                        if (ecnt == ECNT_LAST) begin
                            out_valid <= 1'b1;
                            out_n     <= smc_out_n;
                            state     <= OUT;
                        end
                    end
                end
                OUT: begin
                    out_valid <= 1'b0;
                    out_n     <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    assign W_0 = w_q[0];
    assign W_1 = w_q[1];
    assign W_2 = w_q[2];
    assign W_3 = w_q[3];
    assign W_4 = w_q[4];
    assign W_5 = w_q[5];

    assign V_GS_0 = vgs_q[0];
    assign V_GS_1 = vgs_q[1];
    assign V_GS_2 = vgs_q[2];
    assign V_GS_3 = vgs_q[3];
    assign V_GS_4 = vgs_q[4];
    assign V_GS_5 = vgs_q[5];

    assign V_DS_0 = vds_q[0];
    assign V_DS_1 = vds_q[1];
    assign V_DS_2 = vds_q[2];
    assign V_DS_3 = vds_q[3];
    assign V_DS_4 = vds_q[4];
    assign V_DS_5 = vds_q[5];

endmodule

// File: tb/tb_smc_frame_loader.sv
// Bench for smc_frame_loader: two instances (EVAL_CYCLES 1 and 3) on shared
// stimulus, each compared every cycle against a frame-level reference model.
module tb_smc_frame_loader;
    import smc_pkg::*;

    localparam int NI = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic cmp_en = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid;
    logic [2:0]   in_w, in_vgs, in_vds;
    logic [1:0]   in_mode;
    logic [7:0]   smc_out_n;

    logic [2:0] w_o [NI][N_MOS];
    logic [2:0] g_o [NI][N_MOS];
    logic [2:0] d_o [NI][N_MOS];
    logic [1:0] m_o [NI];
    logic       ov_o [NI];
    logic [7:0] on_o [NI];
    logic       busy_o [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        smc_frame_loader #(.EVAL_CYCLES(gi == 0 ? 1 : 3)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
            .in_w(in_w), .in_vgs(in_vgs), .in_vds(in_vds), .in_mode(in_mode),
            .W_0(w_o[gi][0]), .W_1(w_o[gi][1]), .W_2(w_o[gi][2]),
            .W_3(w_o[gi][3]), .W_4(w_o[gi][4]), .W_5(w_o[gi][5]),
            .V_GS_0(g_o[gi][0]), .V_GS_1(g_o[gi][1]), .V_GS_2(g_o[gi][2]),
            .V_GS_3(g_o[gi][3]), .V_GS_4(g_o[gi][4]), .V_GS_5(g_o[gi][5]),
            .V_DS_0(d_o[gi][0]), .V_DS_1(d_o[gi][1]), .V_DS_2(d_o[gi][2]),
            .V_DS_3(d_o[gi][3]), .V_DS_4(d_o[gi][4]), .V_DS_5(d_o[gi][5]),
            .mode(m_o[gi]), .smc_out_n(smc_out_n),
            .out_valid(ov_o[gi]), .out_n(on_o[gi]), .busy(busy_o[gi])
        );
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int inst,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got %0h want %0h",
                     nm, inst, $time, act, exp);
        end
    endtask

    function automatic int ev(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Frame-level model: beats accepted so far, and the edge at which the
    // pending frame releases the block (result shows one edge earlier).
    int         cyc = 0;
    int         beats [NI] = '{default: 0};
    int         end_at [NI] = '{default: -1};
    logic [2:0] mw [NI][N_MOS] = '{default: '0};
    logic [2:0] mg [NI][N_MOS] = '{default: '0};
    logic [2:0] md [NI][N_MOS] = '{default: '0};
    logic [1:0] mm [NI] = '{default: '0};
    logic       mov [NI] = '{default: 1'b0};
    logic [7:0] mon [NI] = '{default: '0};
    logic       mbusy [NI] = '{default: 1'b0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0;
            for (int i = 0; i < NI; i++) begin
                beats[i] = 0; end_at[i] = -1; mm[i] = '0;
                mov[i] = 1'b0; mon[i] = '0; mbusy[i] = 1'b0;
                for (int k = 0; k < N_MOS; k++) begin
                    mw[i][k] = '0; mg[i][k] = '0; md[i][k] = '0;
                end
            end
        end else begin
            cyc++;
            for (int i = 0; i < NI; i++) begin
                mov[i] = 1'b0;
                mon[i] = '0;
                if (end_at[i] >= cyc) begin
                    if (cyc == end_at[i] - 1) begin
                        mov[i] = 1'b1;
                        mon[i] = smc_out_n;
                    end
                end else if (in_valid) begin
                    if (beats[i] == 0) mm[i] = in_mode;
                    mw[i][beats[i]] = in_w;
                    mg[i][beats[i]] = in_vgs;
                    md[i][beats[i]] = in_vds;
                    beats[i]++;
                    if (beats[i] == N_MOS) begin
                        beats[i]  = 0;
                        end_at[i] = cyc + 2 + ev(i);
                    end
                end else begin
                    beats[i] = 0;
                end
                mbusy[i] = (beats[i] > 0) || (end_at[i] > cyc);
            end
        end
    end

    logic [53:0] ab, eb;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && cmp_en) begin
            for (int i = 0; i < NI; i++) begin
                for (int k = 0; k < N_MOS; k++) begin
                    ab[k*9 +: 9] = {w_o[i][k], g_o[i][k], d_o[i][k]};
                    eb[k*9 +: 9] = {mw[i][k], mg[i][k], md[i][k]};
                end
                chk("bus", i, 64'(ab), 64'(eb));
                chk("mode", i, 64'(m_o[i]), 64'(mm[i]));
                chk("out_valid", i, 64'(ov_o[i]), 64'(mov[i]));
                chk("out_n", i, 64'(on_o[i]), 64'(mon[i]));
                chk("busy", i, 64'(busy_o[i]), 64'(mbusy[i]));
            end
        end
    end

    // Drives nb beats of (k, 7-k, k+1); mode is only legal on beat 0.
    task automatic frame(input logic [1:0] mdv, input logic [7:0] stub,
                         input int nb);
        for (int k = 0; k < nb; k++) begin
            in_valid  = 1'b1;
            in_w      = 3'(k);
            in_vgs    = 3'(7 - k);
            in_vds    = 3'((k + 1) % 8);
            in_mode   = (k == 0) ? mdv : ~mdv;
            smc_out_n = stub;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_w     = 3'($urandom);
        in_vgs   = 3'($urandom);
        in_vds   = 3'($urandom);
        in_mode  = 2'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_w = '0; in_vgs = '0; in_vds = '0; in_mode = '0;
        smc_out_n = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        repeat (20) @(negedge clk);
        chk("idle_busy", 0, 64'(busy_o[0]), 64'd0);
        chk("idle_ov", 0, 64'(ov_o[0]), 64'd0);
        chk("idle_outn", 0, 64'(on_o[0]), 64'd0);
        chk("idle_w5", 0, 64'(w_o[0][5]), 64'd0);
        chk("idle_mode", 1, 64'(m_o[1]), 64'd0);

        frame(2'd2, 8'd77, 6);
        @(negedge clk);
        chk("nom_ov_early", 0, 64'(ov_o[0]), 64'd0);
        @(negedge clk);
        chk("nom_ov", 0, 64'(ov_o[0]), 64'd1);
        chk("nom_outn", 0, 64'(on_o[0]), 64'd77);
        chk("nom_w3", 0, 64'(w_o[0][3]), 64'd3);
        chk("nom_vgs3", 0, 64'(g_o[0][3]), 64'd4);
        chk("nom_vds5", 0, 64'(d_o[0][5]), 64'd6);
        chk("nom_mode", 0, 64'(m_o[0]), 64'd2);
        chk("nom_busy_out", 0, 64'(busy_o[0]), 64'd1);
        @(negedge clk);
        chk("nom_ov_late", 0, 64'(ov_o[0]), 64'd0);
        chk("nom_outn_late", 0, 64'(on_o[0]), 64'd0);
        chk("nom_busy_end", 0, 64'(busy_o[0]), 64'd0);
        @(negedge clk);
        chk("nom3_ov", 1, 64'(ov_o[1]), 64'd1);
        chk("nom3_outn", 1, 64'(on_o[1]), 64'd77);
        repeat (4) @(negedge clk);

        frame(2'd1, 8'd33, 4);
        @(negedge clk);
        chk("abort_busy", 0, 64'(busy_o[0]), 64'd0);
        repeat (3) @(negedge clk);
        chk("abort_ov", 0, 64'(ov_o[0]), 64'd0);
        repeat (4) @(negedge clk);
        frame(2'd3, 8'd5, 6);
        repeat (2) @(negedge clk);
        chk("after_abort_outn", 0, 64'(on_o[0]), 64'd5);
        repeat (6) @(negedge clk);

        frame(2'd0, 8'd10, 6);
        repeat (2) @(negedge clk);
        chk("b2b1_ov", 0, 64'(ov_o[0]), 64'd1);
        chk("b2b1_outn", 0, 64'(on_o[0]), 64'd10);
        @(negedge clk);
        chk("b2b_gap_busy", 0, 64'(busy_o[0]), 64'd0);
        frame(2'd1, 8'd200, 6);
        repeat (2) @(negedge clk);
        chk("b2b2_ov", 0, 64'(ov_o[0]), 64'd1);
        chk("b2b2_outn", 0, 64'(on_o[0]), 64'd200);
        repeat (6) @(negedge clk);

        frame(2'd2, 8'd1, 6);
        smc_out_n = 8'd99;
        repeat (3) @(negedge clk);
        chk("e3_ov_early", 1, 64'(ov_o[1]), 64'd0);
        @(negedge clk);
        chk("e3_ov", 1, 64'(ov_o[1]), 64'd1);
        chk("e3_outn", 1, 64'(on_o[1]), 64'd99);
        repeat (4) @(negedge clk);

        frame(2'd3, 8'd44, 6);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 0, 64'(busy_o[0]), 64'd0);
        chk("arst_mode", 0, 64'(m_o[0]), 64'd0);
        chk("arst_w3", 0, 64'(w_o[0][3]), 64'd0);
        chk("arst_ov", 1, 64'(ov_o[1]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        frame(2'd1, 8'd123, 6);
        repeat (2) @(negedge clk);
        chk("post_rst_outn", 0, 64'(on_o[0]), 64'd123);
        chk("post_rst_mode", 0, 64'(m_o[0]), 64'd1);
        repeat (6) @(negedge clk);

        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 9) != 0);
            in_w      = 3'($urandom);
            in_vgs    = 3'($urandom);
            in_vds    = 3'($urandom);
            in_mode   = 2'($urandom);
            smc_out_n = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (15) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
